id_stage_pipelined: RTL

- Parametrised next-generation RV32 decode stage: decodes `instr_i`, reads the internal register file and registers the result into an ID/EX pipeline register.
- Valid/ready handshakes on both sides.
- Adds what the current decoder lacks:
  - interlocks against in-flight writers in EX and MEM;
  - write-back bypass;
  - flush;
  - illegal-instruction flagging;
  - RV32E-sized register file;
  - stall counter.
- Sits between IF and EX in the 5-stage in-order core.

---
 rtl/id_stage_pipelined_pkg.sv | 70 +++++++
 rtl/id_stage_pipelined_regbank.sv | 56 +++++
 rtl/id_stage_pipelined.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_pipelined_pkg.sv
// ============================================================================
// Module : i_formats (package)
// Brief  : RV32 opcode constants, ID/EX control bundle, immediate extractors.
// Rev    : 1.0 - initial parametrised decode-stage release
// ============================================================================
`default_nettype none

package i_formats;

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    localparam logic [11:0] c_IMM_ECALL  = 12'h000;
    localparam logic [11:0] c_IMM_EBREAK = 12'h001;
    localparam logic [11:0] c_IMM_MRET   = 12'h302;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [2:0] mem_op;
        logic       sub;
        logic       shdir;
        logic [4:0] shamt;
        logic [4:0] rd_addr;
        logic       rd_we;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic       is_ecall;
        logic       is_ebreak;
        logic       is_mret;
        logic       is_fence;
        logic       is_fence_i;
        logic       illegal;
    } id_ex_ctrl_t;

    // Extractors return 32-bit signed values; the stage sign-extends to XLEN.
    function automatic logic signed [31:0] imm_i(input logic [31:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction

    function automatic logic signed [31:0] imm_s(input logic [31:0] i);
        return {{20{i[31]}}, i[31:25], i[11:7]};
    endfunction

    function automatic logic signed [31:0] imm_b(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic signed [31:0] imm_u(input logic [31:0] i);
        return {i[31:12], 12'b0};
    endfunction

    function automatic logic signed [31:0] imm_j(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_stage_pipelined_regbank.sv
// ============================================================================
// Module : regbank_param
// Brief  : Two-read/one-write register file with optional WB read bypass.
// Rev    : 1.0 - initial parametrised decode-stage release
// ============================================================================
`default_nettype none

module regbank_param #(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int BYPASS_WB = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [4:0]      i_raddr1,
    input  logic [4:0]      i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);

    localparam int         c_AW     = $clog2(NUM_REGS);
    localparam logic [5:0] c_NREGS  = 6'(NUM_REGS);
    localparam logic       c_BYPASS = (BYPASS_WB != 0);

    logic [XLEN-1:0] r_regs [NUM_REGS];
    logic            w_wr_ok;

    assign w_wr_ok = i_we && (i_waddr != 5'd0) && ({1'b0, i_waddr} < c_NREGS);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[i_waddr[c_AW-1:0]] <= i_wdata;
        end
    end

    function automatic logic [XLEN-1:0] rd_port(input logic [4:0] a, input logic [XLEN-1:0] v);
        if (a == 5'd0 || {1'b0, a} >= c_NREGS) return '0;
        return v;
    endfunction

    // Bypass returns the value being written this cycle so a same-cycle reader sees it.
    always_comb begin
        o_rdata1 = rd_port(i_raddr1, r_regs[i_raddr1[c_AW-1:0]]);
        o_rdata2 = rd_port(i_raddr2, r_regs[i_raddr2[c_AW-1:0]]);
        if (c_BYPASS && i_we && i_waddr == i_raddr1 && i_raddr1 != 5'd0) o_rdata1 = i_wdata;
        if (c_BYPASS && i_we && i_waddr == i_raddr2 && i_raddr2 != 5'd0) o_rdata2 = i_wdata;
    end

endmodule

`default_nettype wire

// File: rtl/id_stage_pipelined.sv
// ============================================================================
// Module : id_stage_pipelined
// Brief  : RV32 decode stage with interlocks, WB bypass, flush and ID/EX reg.
// Rev    : 1.0 - initial parametrised decode-stage release
// ============================================================================
`default_nettype none

module id_stage_pipelined
    import i_formats::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int BYPASS_WB = 1,
    parameter int CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             if_valid_i,
    output logic             if_ready_o,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [31:0]      instr_i,
    input  logic             flush_i,
    output logic             ex_valid_o,
    input  logic             ex_ready_i,
    output logic [XLEN-1:0]  ex_pc_o,
    output logic [XLEN-1:0]  ex_op1_o,
    output logic [XLEN-1:0]  ex_op2_o,
    output logic [XLEN-1:0]  ex_rs2_o,
    output logic [XLEN-1:0]  ex_imm_o,
    output id_ex_ctrl_t      ex_ctrl_o,
    input  logic             mem_rd_we_i,
    input  logic [4:0]       mem_rd_addr_i,
    input  logic             wb_we_i,
    input  logic [4:0]       wb_addr_i,
    input  logic [XLEN-1:0]  wb_data_i,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [5:0] c_NREGS    = 6'(NUM_REGS);
    localparam logic       c_WB_STALL = (BYPASS_WB == 0);

    logic [6:0]        w_opcode;
    logic [2:0]        w_f3;
    logic [4:0]        w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0]   w_rs1_val, w_rs2_val, w_op1, w_op2, w_imm;
    logic signed [31:0] w_imm32;
    logic              w_use1, w_use2, w_known, w_bad, w_illegal;
    logic              w_hit1, w_hit2, w_hazard, w_free, w_accept, w_stall;
    id_ex_ctrl_t       w_ctrl;

    logic              r_valid;
    logic [XLEN-1:0]   r_pc, r_op1, r_op2, r_rs2, r_imm;
    id_ex_ctrl_t       r_ctrl;
    logic [CNT_W-1:0]  r_cnt;

    assign w_opcode = instr_i[6:0];
    assign w_f3     = instr_i[14:12];
    assign w_rs1    = instr_i[19:15];
    assign w_rs2    = instr_i[24:20];
    assign w_rd     = instr_i[11:7];

    regbank_param #(
        .XLEN      (XLEN),
        .NUM_REGS  (NUM_REGS),
        .BYPASS_WB (BYPASS_WB)
    ) u_regbank (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_we     (wb_we_i),
        .i_waddr  (wb_addr_i),
        .i_wdata  (wb_data_i),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rs1_val),
        .o_rdata2 (w_rs2_val)
    );

    always_comb begin
        w_ctrl         = '0;
        w_use1         = 1'b0;
        w_use2         = 1'b0;
        w_known        = 1'b1;
        w_bad          = 1'b0;
        w_imm32        = '0;
        w_ctrl.alu_op  = w_f3;
        w_ctrl.sub     = instr_i[30] & instr_i[5];
        w_ctrl.shdir   = instr_i[30];
        w_ctrl.shamt   = instr_i[24:20];
        w_ctrl.rd_addr = w_rd;
        case (w_opcode)
            c_OP_R: begin
                w_use1 = 1'b1; w_use2 = 1'b1; w_ctrl.rd_we = 1'b1;
                w_ctrl.shamt = w_rs2_val[4:0];
            end
            c_OP_IMM: begin
                w_use1 = 1'b1; w_ctrl.rd_we = 1'b1; w_imm32 = imm_i(instr_i);
            end
            c_OP_LOAD: begin
                w_use1 = 1'b1; w_ctrl.rd_we = 1'b1; w_ctrl.is_load = 1'b1;
                w_ctrl.alu_op = 3'b000; w_ctrl.mem_op = w_f3; w_imm32 = imm_i(instr_i);
            end
            c_OP_JALR: begin
                w_use1 = 1'b1; w_ctrl.rd_we = 1'b1; w_ctrl.is_jalr = 1'b1;
                w_imm32 = imm_i(instr_i);
            end
            c_OP_STORE: begin
                w_use1 = 1'b1; w_use2 = 1'b1; w_ctrl.is_store = 1'b1;
                w_ctrl.alu_op = 3'b000; w_ctrl.mem_op = w_f3; w_imm32 = imm_s(instr_i);
            end
            c_OP_BRANCH: begin
                w_use1 = 1'b1; w_use2 = 1'b1; w_ctrl.is_branch = 1'b1;
                w_imm32 = imm_b(instr_i);
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_ctrl.rd_we = 1'b1; w_ctrl.alu_op = 3'b000; w_imm32 = imm_u(instr_i);
            end
            c_OP_JAL: begin
                w_ctrl.rd_we = 1'b1; w_ctrl.is_jal = 1'b1; w_imm32 = imm_j(instr_i);
            end
            c_OP_FENCE: begin
                w_imm32           = imm_i(instr_i);
                w_ctrl.is_fence   = (w_f3 == 3'b000);
                w_ctrl.is_fence_i = (w_f3 == 3'b001);
                w_bad             = (w_f3[2:1] != 2'b00);
            end
            c_OP_SYSTEM: begin
                w_imm32 = imm_i(instr_i);
                if (w_f3 != 3'b000) w_bad = 1'b1;
                else begin
                    case (instr_i[31:20])
                        c_IMM_ECALL:  w_ctrl.is_ecall  = 1'b1;
                        c_IMM_EBREAK: w_ctrl.is_ebreak = 1'b1;
                        c_IMM_MRET:   w_ctrl.is_mret   = 1'b1;
                        default:      w_bad            = 1'b1;
                    endcase
                end
            end
            default: w_known = 1'b0;
        endcase

        w_illegal = !w_known || w_bad
                  || (w_use1 && {1'b0, w_rs1} >= c_NREGS)
                  || (w_use2 && {1'b0, w_rs2} >= c_NREGS)
                  || (w_ctrl.rd_we && {1'b0, w_rd} >= c_NREGS);
        // An illegal instruction travels down as a flagged NOP with no side effects.
        if (w_illegal) begin
            w_ctrl.illegal    = 1'b1;
            w_ctrl.rd_we      = 1'b0;
            w_ctrl.mem_op     = 3'b000;
            w_ctrl.is_load    = 1'b0;
            w_ctrl.is_store   = 1'b0;
            w_ctrl.is_branch  = 1'b0;
            w_ctrl.is_jal     = 1'b0;
            w_ctrl.is_jalr    = 1'b0;
            w_ctrl.is_ecall   = 1'b0;
            w_ctrl.is_ebreak  = 1'b0;
            w_ctrl.is_mret    = 1'b0;
            w_ctrl.is_fence   = 1'b0;
            w_ctrl.is_fence_i = 1'b0;
        end
    end

    assign w_imm = XLEN'(w_imm32);
    assign w_op1 = (w_opcode == c_OP_LUI) ? '0 :
                   (w_opcode == c_OP_AUIPC || w_opcode == c_OP_JAL) ? pc_i : w_rs1_val;
    assign w_op2 = (w_opcode == c_OP_R || w_opcode == c_OP_BRANCH) ? w_rs2_val : w_imm;

    assign w_hit1 = w_use1 && (w_rs1 != 5'd0) &&
                    ((r_valid && r_ctrl.rd_we && r_ctrl.rd_addr == w_rs1) ||
                     (mem_rd_we_i && mem_rd_addr_i == w_rs1) ||
                     (c_WB_STALL && wb_we_i && wb_addr_i == w_rs1));
    assign w_hit2 = w_use2 && (w_rs2 != 5'd0) &&
                    ((r_valid && r_ctrl.rd_we && r_ctrl.rd_addr == w_rs2) ||
                     (mem_rd_we_i && mem_rd_addr_i == w_rs2) ||
                     (c_WB_STALL && wb_we_i && wb_addr_i == w_rs2));

    assign w_hazard   = if_valid_i && (w_hit1 || w_hit2);
    assign w_free     = !r_valid || ex_ready_i;
    assign if_ready_o = rst_ni && (flush_i || (!w_hazard && w_free));
    assign w_accept   = if_valid_i && if_ready_o && !flush_i;
    assign w_stall    = w_hazard && w_free && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_rs2   <= '0;
            r_imm   <= '0;
            r_ctrl  <= '0;
            r_cnt   <= '0;
        end else begin
            if (flush_i) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
                r_pc    <= pc_i;
                r_op1   <= w_op1;
                r_op2   <= w_op2;
                r_rs2   <= w_rs2_val;
                r_imm   <= w_imm;
                r_ctrl  <= w_ctrl;
            end else if (w_free) begin
                r_valid <= 1'b0;
            end
            if (w_stall && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign ex_valid_o  = r_valid;
    assign ex_pc_o     = r_pc;
    assign ex_op1_o    = r_op1;
    assign ex_op2_o    = r_op2;
    assign ex_rs2_o    = r_rs2;
    assign ex_imm_o    = r_imm;
    assign ex_ctrl_o   = r_ctrl;
    assign stall_cnt_o = r_cnt;

endmodule

`default_nettype wire
